// File: rtl/picoblaze_irq_ctrl.sv
// Edge-triggered interrupt controller for the kcpsm3 core.
// Fixed lowest-index priority, one request in service at a time.
module picoblaze_irq_ctrl #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] PORT_MASK = 8'h10,
  parameter logic [7:0] PORT_STAT = 8'h11,
  parameter logic [7:0] PORT_CLR  = 8'h12,
  parameter logic [7:0] PORT_VEC  = 8'h13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  output logic [7:0]       in_data,
  output logic             in_sel,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]       state;
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;
  logic [N_SRC-1:0] hist;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic             vec_valid;
  logic [2:0]       vec_idx;

  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] win_oh;
  logic [2:0]       win_idx;
  logic [N_SRC-1:0] clr_bits;
  logic [N_SRC-1:0] ack_clr;
  logic             wr_mask;
  logic             wr_clr;
  logic             wr_eoi;
  logic             take_ack;
  logic [7:0]       vec_q;

  // read_strobe only qualifies the core's own input mux
  logic unused_ok;
  assign unused_ok = ^{read_strobe, out_port};

  assign edge_det = sync2 & ~hist;
  assign active   = pending & mask;
  assign wr_mask  = write_strobe && (port_id == PORT_MASK);
  assign wr_clr   = write_strobe && (port_id == PORT_CLR);
  assign wr_eoi   = write_strobe && (port_id == PORT_VEC);
  assign take_ack = (state == ST_ASSERT) && interrupt_ack;
  assign clr_bits = wr_clr ? out_port[N_SRC-1:0] : '0;
  assign ack_clr  = take_ack ? win_oh : '0;
  assign vec_q    = {vec_valid, 4'b0000, vec_idx};

  always_comb begin
    win_idx = 3'd0;
    win_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_idx    = 3'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
      end
    end
  end

  always_comb begin
    in_sel  = 1'b0;
    in_data = 8'h00;
    unique case (1'b1)
      (port_id == PORT_MASK): begin
        in_sel  = 1'b1;
        in_data = 8'(mask);
      end
      (port_id == PORT_STAT): begin
        in_sel  = 1'b1;
        in_data = 8'(pending);
      end
      (port_id == PORT_VEC): begin
        in_sel  = 1'b1;
        in_data = vec_q;
      end
      default: begin
        in_sel  = 1'b0;
        in_data = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // a fresh edge beats a clear aimed at the same bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr_bits & ~ack_clr) | edge_det;
      if (wr_mask) mask <= out_port[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      vec_valid <= 1'b0;
      vec_idx   <= 3'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|active) begin
            state     <= ST_ASSERT;
            interrupt <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (interrupt_ack) begin
            vec_valid <= 1'b1;
            vec_idx   <= win_idx;
            interrupt <= 1'b0;
            state     <= ST_SERVICE;
          end else if (!(|active)) begin
            interrupt <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          interrupt <= 1'b0;
          if (wr_eoi) begin
            vec_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          interrupt <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picoblaze_irq_ctrl.sv
// Directed bench for picoblaze_irq_ctrl: register table plus
// hand-written handshake, priority, withdraw, collision and reset cases.
module tb_picoblaze_irq_ctrl;

  localparam logic [7:0] P_MASK = 8'h10;
  localparam logic [7:0] P_STAT = 8'h11;
  localparam logic [7:0] P_CLR  = 8'h12;
  localparam logic [7:0] P_VEC  = 8'h13;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] irq_in = 4'h0;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_data;
  logic       in_sel;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [7:0] wport;
    logic [7:0] wdata;
    logic [7:0] rport;
    logic [7:0] exp_data;
    logic       exp_sel;
  } vec_t;

  vec_t tbl[8];

  picoblaze_irq_ctrl #(.N_SRC(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_in        (irq_in),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_data       (in_data),
    .in_sel        (in_sel),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    out_port     = 8'h00;
    port_id      = 8'h00;
  endtask

  task automatic rd(input string name, input logic [7:0] p,
                    input logic [7:0] exp);
    port_id     = p;
    read_strobe = 1'b1;
    #1;
    check(name, in_data, exp);
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, P_MASK, 8'hFF, P_MASK, 8'h0F, 1'b1};
    tbl[1] = '{1'b0, 8'h00,  8'h00, P_STAT, 8'h00, 1'b1};
    tbl[2] = '{1'b0, 8'h00,  8'h00, P_VEC,  8'h00, 1'b1};
    tbl[3] = '{1'b0, 8'h00,  8'h00, P_CLR,  8'h00, 1'b0};
    tbl[4] = '{1'b0, 8'h00,  8'h00, 8'h00,  8'h00, 1'b0};
    tbl[5] = '{1'b1, P_MASK, 8'h05, P_MASK, 8'h05, 1'b1};
    tbl[6] = '{1'b1, P_CLR,  8'hFF, P_STAT, 8'h00, 1'b1};
    tbl[7] = '{1'b1, P_MASK, 8'h00, P_MASK, 8'h00, 1'b1};

    // reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      irq_in = 4'(i * 5);
      tick();
    end
    check("rst_int", 8'(interrupt), 8'h00);
    rd("rst_mask", P_MASK, 8'h00);
    rd("rst_stat", P_STAT, 8'h00);
    rd("rst_vec", P_VEC, 8'h00);
    irq_in = 4'h0;
    tick();
    reset = 1'b1;
    tick(4);
    rd("idle_stat", P_STAT, 8'h00);

    // register access table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) wr(tbl[i].wport, tbl[i].wdata);
      port_id = tbl[i].rport;
      #1;
      check($sformatf("tbl%0d_data", i), in_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_sel", i), 8'(in_sel), 8'(tbl[i].exp_sel));
      port_id = 8'h00;
    end

    // basic handshake
    wr(P_MASK, 8'h01);
    irq_in = 4'h1;
    tick(2);
    rd("b_stat2", P_STAT, 8'h00);
    tick();
    rd("b_stat3", P_STAT, 8'h01);
    check("b_int3", 8'(interrupt), 8'h00);
    irq_in = 4'h0;
    tick();
    check("b_int4", 8'(interrupt), 8'h01);
    ack();
    check("b_int_ack", 8'(interrupt), 8'h00);
    rd("b_vec", P_VEC, 8'h80);
    rd("b_stat_ack", P_STAT, 8'h00);
    ack();
    check("b_stray_int", 8'(interrupt), 8'h00);
    rd("b_stray_vec", P_VEC, 8'h80);
    wr(P_VEC, 8'h5A);
    rd("b_eoi_vec", P_VEC, 8'h00);
    tick(2);
    check("b_idle_int", 8'(interrupt), 8'h00);

    // priority between two simultaneous edges
    wr(P_MASK, 8'h0F);
    irq_in = 4'hA;
    tick(3);
    irq_in = 4'h0;
    rd("p_stat", P_STAT, 8'h0A);
    tick();
    check("p_int1", 8'(interrupt), 8'h01);
    ack();
    rd("p_vec1", P_VEC, 8'h81);
    rd("p_stat1", P_STAT, 8'h08);
    tick(2);
    check("p_svc_int", 8'(interrupt), 8'h00);
    wr(P_VEC, 8'h00);
    check("p_eoi_int", 8'(interrupt), 8'h00);
    tick();
    check("p_int2", 8'(interrupt), 8'h01);
    ack();
    rd("p_vec2", P_VEC, 8'h83);
    rd("p_stat2", P_STAT, 8'h00);
    wr(P_VEC, 8'h00);

    // withdraw by masking before the ack
    wr(P_MASK, 8'h01);
    irq_in = 4'h1;
    tick(4);
    irq_in = 4'h0;
    check("w_int", 8'(interrupt), 8'h01);
    wr(P_MASK, 8'h00);
    tick();
    check("w_int_fall", 8'(interrupt), 8'h00);
    rd("w_stat", P_STAT, 8'h01);
    wr(P_MASK, 8'h01);
    tick();
    check("w_reassert", 8'(interrupt), 8'h01);
    wr(P_MASK, 8'h00);
    wr(P_CLR, 8'h01);
    rd("w_clr", P_STAT, 8'h00);

    // set beats clear on the same bit
    irq_in = 4'h4;
    tick(2);
    wr(P_CLR, 8'h04);
    rd("c_stat", P_STAT, 8'h04);
    wr(P_CLR, 8'h04);
    rd("c_stat_clr", P_STAT, 8'h00);

    // reset while in service
    irq_in = 4'h0;
    tick(3);
    wr(P_MASK, 8'h04);
    irq_in = 4'h4;
    tick(4);
    check("r_int", 8'(interrupt), 8'h01);
    ack();
    rd("r_vec", P_VEC, 8'h82);
    #2;
    reset = 1'b0;
    #1;
    check("r_int0", 8'(interrupt), 8'h00);
    rd("r_vec0", P_VEC, 8'h00);
    rd("r_mask0", P_MASK, 8'h00);
    rd("r_stat0", P_STAT, 8'h00);
    tick(2);
    reset = 1'b1;
    tick(3);
    rd("r_held_edge", P_STAT, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
